delta_decoder: RTL
==================

DELTA_DECODER -- requirements
Module: delta_decoder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, sample and delta width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, output FIFO entries, power of two, minimum 2.
REQ-003 The block SHALL have port clk  input  1  sole clock; all state updates on posedge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port in_valid  input  1  in_delta/in_first are valid.
REQ-006 The block SHALL have port in_ready  output  1  block can accept a delta this cycle.
REQ-007 The block SHALL have port in_delta  input  WIDTH  difference word, two's complement.
REQ-008 The block SHALL have port in_first  input  1  word is a seed sample, not a difference.
REQ-009 The block SHALL have port out_valid  output  1  out_sample holds the FIFO head.
REQ-010 The block SHALL have port out_ready  input  1  consumer takes the head this cycle.
REQ-011 The block SHALL have port out_sample  output  WIDTH  reconstructed sample, FIFO head.
REQ-012 The block SHALL have port ovf  output  1  sticky signed-overflow flag for the current sequence.
REQ-013 The block SHALL have port sample_count  output  16  samples accepted since last seed, wrapping.

Function
REQ-014 Input accept SHALL occur on a posedge with in_valid=1 and in_ready=1; output pop SHALL occur on a posedge with out_valid=1 and out_ready=1.
REQ-015 in_ready SHALL be 1 exactly when FIFO occupancy < DEPTH, registered, with no combinational path from out_ready.
REQ-016 On accept with in_first=1, the accumulator SHALL load in_delta, ovf SHALL clear to 0 and sample_count SHALL load 1.
REQ-017 On accept with in_first=0, the accumulator SHALL become acc + in_delta modulo 2^WIDTH and sample_count SHALL increment, wrapping from 0xFFFF to 0.
REQ-018 ovf SHALL set when acc and in_delta have equal sign bits and the sum sign differs; it SHALL hold until the next seed or reset.
REQ-019 Each accept SHALL push the new accumulator value into the FIFO in the same edge; latency from accept edge to out_valid=1 on an empty FIFO SHALL be exactly one cycle, i.e. visible after that edge.
REQ-020 The FIFO SHALL deliver samples in acceptance order; out_sample SHALL be stable while out_valid=1 and out_ready=0.
REQ-021 A simultaneous push and pop SHALL leave occupancy unchanged and is legal at any occupancy below DEPTH; at occupancy DEPTH only a pop occurs, because in_ready=0.
REQ-022 Read and write pointers SHALL be log2(DEPTH)+1 bits and wrap naturally; full = same index with opposite MSB, empty = equal pointers.
REQ-023 Accepting in_first=0 before any seed since reset SHALL add to an accumulator value of 0.
REQ-024 in_delta and in_first SHALL be ignored when no accept occurs.

Reset
REQ-025 While reset=1, regardless of clk, the block SHALL set acc=0, FIFO empty, out_valid=0, in_ready=1, ovf=0, sample_count=0 and out_sample=0.
REQ-026 Reset asserted mid-stream SHALL discard all FIFO contents and the accumulator; the first accept after deassertion SHALL follow REQ-016/REQ-023.
REQ-027 in_ready SHALL be 1 on the first posedge after reset deassertion.

Verification
REQ-028 Seed 100, then deltas +5, -3, +0 with out_ready=1 -> out_sample sequence 100, 105, 102, 102, each one cycle after accept; sample_count=4; ovf=0.
REQ-029 Seed 0x7FFFFFFE, delta +3 -> out_sample 0x80000001 and ovf=1; then seed 7 -> ovf=0, out_sample 7.
REQ-030 Seed 1, then deltas +1 every cycle with out_ready=0 -> in_ready drops after 4 accepts; out_ready=1 then drains 1, 2, 3, 4 in order with no loss.
REQ-031 FIFO holding 2 entries, in_valid=1 and out_ready=1 together for 8 cycles -> occupancy stays 2 and output is strictly ordered.
REQ-032 Three samples queued, reset pulsed asynchronously between edges -> out_valid=0 immediately; next accept of delta 9 with in_first=0 -> out_sample 9.
REQ-033 0xFFFF deltas after seed -> sample_count=0 after the 65536th accept.

Source files
------------

// File: rtl/delta_decoder_if.sv
// Delta decoder stream interface: delta input handshake and sample output handshake.
// The producer/consumer side uses master, the decoder uses slave.
interface delta_decoder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_delta;
    logic             in_first;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sample;

    modport master (
        output in_valid, in_delta, in_first, out_ready,
        input  in_ready, out_valid, out_sample
    );

    modport slave (
        input  in_valid, in_delta, in_first, out_ready,
        output in_ready, out_valid, out_sample
    );
endinterface

// File: rtl/delta_decoder.sv
// Delta decoder: accumulates two's complement deltas into samples
// and queues them in a small output FIFO with registered in_ready.
module delta_decoder #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    delta_decoder_if.slave bus,
    output logic        ovf,
    output logic [15:0] sample_count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_acc;
    logic             r_ovf;
    logic [15:0]      r_cnt;
    logic             r_in_ready;
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic             w_push;
    logic             w_pop;
    logic             w_not_empty;
    logic [AW:0]      w_wr_nxt;
    logic [AW:0]      w_rd_nxt;
    logic             w_full_nxt;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_acc_nxt;
    logic             w_ovf_add;

    assign w_not_empty = (r_wr_ptr != r_rd_ptr);
    assign w_push      = bus.in_valid & r_in_ready;
    assign w_pop       = w_not_empty & bus.out_ready;
    assign w_wr_nxt    = r_wr_ptr + (AW+1)'(w_push);
    assign w_rd_nxt    = r_rd_ptr + (AW+1)'(w_pop);
    assign w_full_nxt  = (w_wr_nxt[AW-1:0] == w_rd_nxt[AW-1:0]) &&
                         (w_wr_nxt[AW] != w_rd_nxt[AW]);

    assign w_sum     = r_acc + bus.in_delta;
    assign w_acc_nxt = bus.in_first ? bus.in_delta : w_sum;
    // Signed overflow: operands agree in sign but the sum does not
    assign w_ovf_add = (r_acc[WIDTH-1] == bus.in_delta[WIDTH-1]) &&
                       (w_sum[WIDTH-1] != r_acc[WIDTH-1]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc      <= '0;
            r_ovf      <= 1'b0;
            r_cnt      <= '0;
            r_in_ready <= 1'b1;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else begin
            r_wr_ptr   <= w_wr_nxt;
            r_rd_ptr   <= w_rd_nxt;
            r_in_ready <= ~w_full_nxt;
            if (w_push) begin
                r_acc <= w_acc_nxt;
                if (bus.in_first) begin
                    r_ovf <= 1'b0;
                    r_cnt <= 16'd1;
                end else begin
                    r_ovf <= r_ovf | w_ovf_add;
                    r_cnt <= r_cnt + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= w_acc_nxt;
        end
    end

    assign bus.in_ready   = r_in_ready;
    assign bus.out_valid  = w_not_empty;
    assign bus.out_sample = w_not_empty ? r_mem[r_rd_ptr[AW-1:0]] : '0;
    assign ovf            = r_ovf;
    assign sample_count   = r_cnt;
endmodule
